// File: rtl/score_keeper_pkg.sv
// score_keeper_pkg
//   Shared definitions for the score keeper: match states, side codes and
//   the inactive decimal-point pattern, plus the digit encoder used by the
//   registered display outputs.
package score_keeper_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic       SIDE_L = 1'b0;
  localparam logic       SIDE_R = 1'b1;
  localparam logic [3:0] DP_OFF = 4'hF;

  // x2=1: the display stage halves the value before decode, so emit 2*d.
  function automatic logic [3:0] enc_digit(input logic [3:0] d, input logic x2);
    return x2 ? {d[2:0], 1'b0} : d;
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// bcd_counter2
//   Two-digit BCD score register for one player.
//   clk    in  system clock
//   reset  in  synchronous active-low reset
//   clr    in  clear both digits (restart)
//   inc    in  add one goal
//   tens   out tens digit
//   units  out units digit
module bcd_counter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc) begin
      if (units_q == 4'd9) begin
        units_d = '0;
        // Tens saturates at 9; the win limit keeps scores below 100 anyway.
        tens_d  = (tens_q == 4'd9) ? tens_q : tens_q + 4'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;

endmodule

// File: rtl/score_keeper.sv
// score_keeper
//   Counts goals per player, runs the match (post-goal lockout, win, restart)
//   and produces registered hex digits and decimal points for the display mux.
//   clk        in   system clock
//   reset      in   synchronous active-low reset
//   goal_l/r   in   goal detector levels (rising edge = one goal)
//   restart    in   debounced restart level (rising edge restarts)
//   hex3/hex2  out  left tens/units digit
//   hex1/hex0  out  right tens/units digit
//   dp_out     out  decimal points, active low, bit i pairs with hex i
//   goal_evt   out  one-cycle pulse per accepted goal
//   game_over  out  high while the match is over
//   winner     out  0 = left, 1 = right (valid with game_over)
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned BLINK_BIT   = 22,
  parameter int unsigned HEX_X2      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       goal_l,
  input  logic       goal_r,
  input  logic       restart,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_out,
  output logic       goal_evt,
  output logic       game_over,
  output logic       winner
);

  if (WIN_SCORE < 1 || WIN_SCORE > 99 || (HEX_X2 != 0 && WIN_SCORE > 7)) begin : g_bad_win
    $error("score_keeper: WIN_SCORE out of range for HEX_X2 setting");
  end
  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("score_keeper: HOLD_CYCLES must be at least 2");
  end

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic goal_l_q, goal_r_q, restart_q;
  logic rise_l, rise_r, rise_rs;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                side_q, side_d;
  logic [BLINK_BIT:0]  blink_q;

  logic       inc_l, inc_r, clr, accept;
  logic [3:0] tens_l, units_l, tens_r, units_r;
  logic [6:0] score_l, score_r;
  logic       win_l, win_r;

  logic [3:0] hex3_q, hex2_q, hex1_q, hex0_q;
  logic [3:0] dp_q, dp_d;
  logic       evt_q;

  assign rise_l  = goal_l  & ~goal_l_q;
  assign rise_r  = goal_r  & ~goal_r_q;
  assign rise_rs = restart & ~restart_q;

  bcd_counter2 u_left (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc_l),
    .tens  (tens_l),
    .units (units_l)
  );

  bcd_counter2 u_right (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc_r),
    .tens  (tens_r),
    .units (units_r)
  );

  assign score_l = 7'(tens_l) * 7'd10 + 7'(units_l);
  assign score_r = 7'(tens_r) * 7'd10 + 7'(units_r);
  assign win_l   = (score_l + 7'd1) == 7'(WIN_SCORE);
  assign win_r   = (score_r + 7'd1) == 7'(WIN_SCORE);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    side_d  = side_q;
    inc_l   = 1'b0;
    inc_r   = 1'b0;
    clr     = 1'b0;
    accept  = 1'b0;
    if (rise_rs) begin
      state_d = ST_PLAY;
      hold_d  = '0;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          // Simultaneous edges cancel: neither side is credited.
          if (rise_l ^ rise_r) begin
            accept  = 1'b1;
            inc_l   = rise_l;
            inc_r   = rise_r;
            side_d  = rise_r ? SIDE_R : SIDE_L;
            hold_d  = '0;
            state_d = (rise_l ? win_l : win_r) ? ST_OVER : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = ST_PLAY;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        ST_OVER: ;
        default: state_d = ST_PLAY;
      endcase
    end
  end

  always_comb begin
    dp_d = DP_OFF;
    unique case (state_q)
      ST_HOLD: dp_d = (side_q == SIDE_L) ? {{2{blink_q[BLINK_BIT]}}, 2'b11}
                                         : {2'b11, {2{blink_q[BLINK_BIT]}}};
      ST_OVER: dp_d = (side_q == SIDE_L) ? 4'b0011 : 4'b1100;
      default: dp_d = DP_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      goal_l_q  <= 1'b0;
      goal_r_q  <= 1'b0;
      restart_q <= 1'b0;
      state_q   <= ST_PLAY;
      hold_q    <= '0;
      side_q    <= SIDE_L;
      blink_q   <= '0;
      hex3_q    <= '0;
      hex2_q    <= '0;
      hex1_q    <= '0;
      hex0_q    <= '0;
      dp_q      <= DP_OFF;
      evt_q     <= 1'b0;
    end else begin
      goal_l_q  <= goal_l;
      goal_r_q  <= goal_r;
      restart_q <= restart;
      state_q   <= state_d;
      hold_q    <= hold_d;
      side_q    <= side_d;
      blink_q   <= blink_q + 1'b1;
      hex3_q    <= enc_digit(tens_l,  HEX_X2 != 0);
      hex2_q    <= enc_digit(units_l, HEX_X2 != 0);
      hex1_q    <= enc_digit(tens_r,  HEX_X2 != 0);
      hex0_q    <= enc_digit(units_r, HEX_X2 != 0);
      dp_q      <= dp_d;
      evt_q     <= accept;
    end
  end

  assign hex3      = hex3_q;
  assign hex2      = hex2_q;
  assign hex1      = hex1_q;
  assign hex0      = hex0_q;
  assign dp_out    = dp_q;
  assign goal_evt  = evt_q;
  assign game_over = (state_q == ST_OVER);
  assign winner    = game_over & side_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper
//   Directed bench for score_keeper. DUT a: WIN_SCORE=7, HEX_X2=1, HOLD=100.
//   DUT b: WIN_SCORE=12, HEX_X2=0, HOLD=20. Expected hex words come from a
//   small score model and pass through a scoreboard queue.
module tb_score_keeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       gl_a, gr_a, rs_a, gl_b, gr_b, rs_b;
  logic [3:0] h3_a, h2_a, h1_a, h0_a, dp_a, h3_b, h2_b, h1_b, h0_b, dp_b;
  logic       evt_a, go_a, win_a, evt_b, go_b, win_b;
  logic [15:0] hex_a, hex_b;

  assign hex_a = {h3_a, h2_a, h1_a, h0_a};
  assign hex_b = {h3_b, h2_b, h1_b, h0_b};

  score_keeper #(.WIN_SCORE(7), .HOLD_CYCLES(100), .BLINK_BIT(3), .HEX_X2(1)) dut_a (
    .clk(clk), .reset(reset), .goal_l(gl_a), .goal_r(gr_a), .restart(rs_a),
    .hex3(h3_a), .hex2(h2_a), .hex1(h1_a), .hex0(h0_a), .dp_out(dp_a),
    .goal_evt(evt_a), .game_over(go_a), .winner(win_a)
  );

  score_keeper #(.WIN_SCORE(12), .HOLD_CYCLES(20), .BLINK_BIT(3), .HEX_X2(0)) dut_b (
    .clk(clk), .reset(reset), .goal_l(gl_b), .goal_r(gr_b), .restart(rs_b),
    .hex3(h3_b), .hex2(h2_b), .hex1(h1_b), .hex0(h0_b), .dp_out(dp_b),
    .goal_evt(evt_b), .game_over(go_b), .winner(win_b)
  );

  typedef struct {
    string       tag;
    logic [15:0] hex;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   evt_cnt_a = 0;
  int   evt_cnt_b = 0;
  int   l_s[2];
  int   r_s[2];

  always @(negedge clk) begin
    if (evt_a === 1'b1) evt_cnt_a++;
    if (evt_b === 1'b1) evt_cnt_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] dig(input int d, input bit x2);
    return x2 ? 4'(d * 2) : 4'(d);
  endfunction

  function automatic logic [15:0] enc(input int l, input int r, input bit x2);
    return {dig(l / 10, x2), dig(l % 10, x2), dig(r / 10, x2), dig(r % 10, x2)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit d, input bit side, input logic v);
    if (d) begin
      if (side) gr_b = v; else gl_b = v;
    end else begin
      if (side) gr_a = v; else gl_a = v;
    end
  endtask

  task automatic pop(input bit d);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk(e.tag, d ? hex_b : hex_a, e.hex);
    end
  endtask

  // One-cycle goal pulse; checks goal_evt at N+1, old hex at N+1, new hex at N+2.
  task automatic goal(input bit d, input bit side, input bit acc, input string tag);
    logic [15:0] pre;
    exp_t        e;
    pre = enc(l_s[d], r_s[d], d == 1'b0);
    if (acc) begin
      if (side) r_s[d]++; else l_s[d]++;
    end
    e.tag = tag;
    e.hex = enc(l_s[d], r_s[d], d == 1'b0);
    sb.push_back(e);
    drive(d, side, 1'b1);
    step(1);
    chk({tag, "_evt"}, 16'(d ? evt_b : evt_a), 16'(acc));
    chk({tag, "_pre"}, d ? hex_b : hex_a, pre);
    drive(d, side, 1'b0);
    step(1);
    pop(d);
  endtask

  initial begin
    int  c0;
    bit  seen0, seen1, badpair;
    exp_t e;

    reset = 1'b0;
    gl_a = 0; gr_a = 0; rs_a = 0; gl_b = 0; gr_b = 0; rs_b = 0;
    l_s = '{0, 0};
    r_s = '{0, 0};

    // 1: reset
    step(3);
    reset = 1'b1;
    step(1);
    chk("rst_hex_a", hex_a, 16'h0000);
    chk("rst_dp_a", 16'(dp_a), 16'hF);
    chk("rst_flags_a", 16'({go_a, evt_a, win_a}), 16'h0);
    chk("rst_hex_b", hex_b, 16'h0000);
    chk("rst_dp_b", 16'(dp_b), 16'hF);

    // 2: held goal_l counts once, blink on left pair, re-pulse ignored in HOLD
    c0 = evt_cnt_a;
    l_s[0] = 1;
    e.tag = "held_goal_l";
    e.hex = enc(1, 0, 1'b1);
    sb.push_back(e);
    gl_a = 1'b1;
    step(1);
    chk("held_evt", 16'(evt_a), 16'h1);
    chk("held_pre", hex_a, 16'h0000);
    step(1);
    pop(1'b0);
    step(8);
    gl_a = 1'b0;
    seen0 = 0; seen1 = 0; badpair = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (dp_a[1:0] !== 2'b11 || dp_a[3] !== dp_a[2]) badpair = 1;
      if (dp_a[3:2] === 2'b00) seen0 = 1;
      if (dp_a[3:2] === 2'b11) seen1 = 1;
    end
    chk("hold_dp_pairs", 16'(badpair), 16'h0);
    chk("hold_blink", 16'({seen0, seen1}), 16'h3);
    goal(1'b0, 1'b0, 1'b0, "hold_ignore");
    chk("held_evt_count", 16'(evt_cnt_a - c0), 16'h1);
    step(60);
    chk("hold_end_dp", 16'(dp_a), 16'hF);

    // 3: simultaneous edges cancel
    c0 = evt_cnt_a;
    gl_a = 1'b1; gr_a = 1'b1;
    step(1);
    chk("simul_evt", 16'(evt_a), 16'h0);
    gl_a = 1'b0; gr_a = 1'b0;
    step(2);
    chk("simul_hex", hex_a, enc(1, 0, 1'b1));
    chk("simul_dp", 16'(dp_a), 16'hF);
    chk("simul_cnt", 16'(evt_cnt_a - c0), 16'h0);

    // 4: right wins with seven goals
    for (int k = 1; k <= 7; k++) begin
      goal(1'b0, 1'b1, 1'b1, $sformatf("right_goal%0d", k));
      if (k < 7) step(105);
    end
    chk("win_hex0", 16'(h0_a), 16'hE);
    chk("win_dp", 16'(dp_a), 16'b1100);
    chk("win_flags", 16'({go_a, win_a}), 16'h3);
    goal(1'b0, 1'b0, 1'b0, "over_ignore_l");
    goal(1'b0, 1'b1, 1'b0, "over_ignore_r");

    // 5: BCD carry and left win on DUT b
    for (int k = 1; k <= 12; k++) begin
      goal(1'b1, 1'b0, 1'b1, $sformatf("b_left%0d", k));
      if (k == 10) chk("b_carry_hex32", 16'({h3_b, h2_b}), 16'h10);
      if (k < 12) begin
        chk("b_not_over", 16'(go_b), 16'h0);
        step(25);
      end
    end
    chk("b_win_dp", 16'(dp_b), 16'b0011);
    chk("b_win_flags", 16'({go_b, win_b}), 16'h2);

    // 6: restart from OVER, restart racing a goal, reset mid-HOLD
    rs_a = 1'b1;
    step(1);
    chk("rs_over_evt", 16'(evt_a), 16'h0);
    rs_a = 1'b0;
    step(1);
    l_s[0] = 0; r_s[0] = 0;
    chk("rs_over_hex", hex_a, 16'h0000);
    chk("rs_over_dp", 16'(dp_a), 16'hF);
    chk("rs_over_go", 16'(go_a), 16'h0);
    goal(1'b0, 1'b0, 1'b1, "post_rs_goal");
    step(105);
    rs_a = 1'b1; gl_a = 1'b1;
    step(1);
    chk("rs_race_evt", 16'(evt_a), 16'h0);
    rs_a = 1'b0; gl_a = 1'b0;
    step(1);
    l_s[0] = 0; r_s[0] = 0;
    chk("rs_race_hex", hex_a, 16'h0000);
    chk("rs_race_dp", 16'(dp_a), 16'hF);
    goal(1'b0, 1'b1, 1'b1, "rs_race_play");
    step(10);
    reset = 1'b0;
    step(1);
    chk("rst_hold_hex", hex_a, 16'h0000);
    chk("rst_hold_dp", 16'(dp_a), 16'hF);
    chk("rst_hold_flags", 16'({go_a, evt_a, win_a}), 16'h0);
    reset = 1'b1;
    l_s[0] = 0; r_s[0] = 0;
    goal(1'b0, 1'b0, 1'b1, "no_lockout");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
